// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per clock.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready/in_data
// word input; ser_out serial bit, ser_frame data-valid strobe,
// ser_last final-bit strobe.
module shift_reg_piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic [WIDTH-1:0] w_shifted;
  logic             w_cnt_zero;
  logic             w_xfer;
  logic             w_head;

  assign w_cnt_zero = (r_cnt == '0);
  assign in_ready   = (r_state == IDLE) || w_cnt_zero;
  assign w_xfer     = in_valid && in_ready;

  // Output end is bit WIDTH-1 for MSB-first, bit 0 otherwise.
  assign w_shifted = (MSB_FIRST != 0) ?
                     {r_sh[WIDTH-2:0], 1'b0} :
                     {1'b0, r_sh[WIDTH-1:1]};
  assign w_head    = (MSB_FIRST != 0) ?
                     r_sh[WIDTH-1] : r_sh[0];

  // Outputs decode registered state only; gating with SHIFT keeps
  // the line at 0 while idle regardless of register contents.
  assign ser_frame = (r_state == SHIFT);
  assign ser_last  = (r_state == SHIFT) && w_cnt_zero;
  assign ser_out   = (r_state == SHIFT) && w_head;

  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_sh_n    = in_data;
          w_cnt_n   = CW'(WIDTH - 1);
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_cnt_zero) begin
          w_sh_n  = w_shifted;
          w_cnt_n = r_cnt - 1'b1;
        end else if (w_xfer) begin
          w_sh_n  = in_data;
          w_cnt_n = CW'(WIDTH - 1);
        end else begin
          // Final shift flushes the register to all zeros.
          w_sh_n    = w_shifted;
          w_state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sh    <= w_sh_n;
      r_cnt   <= w_cnt_n;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx: an MSB-first and an
// LSB-first instance, checked against hand-computed bit sequences.
module tb_shift_reg_piso_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_valid, m_ready, m_out, m_frame, m_last;
  logic [7:0] m_data;
  logic       l_valid, l_ready, l_out, l_frame, l_last;
  logic [7:0] l_data;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (m_valid),
    .in_ready  (m_ready),
    .in_data   (m_data),
    .ser_out   (m_out),
    .ser_frame (m_frame),
    .ser_last  (m_last)
  );

  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (l_valid),
    .in_ready  (l_ready),
    .in_data   (l_data),
    .ser_out   (l_out),
    .ser_frame (l_frame),
    .ser_last  (l_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(string tag, bit lsb,
                          logic o, logic f, logic la, logic r);
    chk({tag, ".out"},   lsb ? l_out   : m_out,   {7'd0, o});
    chk({tag, ".frame"}, lsb ? l_frame : m_frame, {7'd0, f});
    chk({tag, ".last"},  lsb ? l_last  : m_last,  {7'd0, la});
    chk({tag, ".ready"}, lsb ? l_ready : m_ready, {7'd0, r});
  endtask

  // One-cycle transfer; returns sampling cycle k+1.
  task automatic send(bit lsb, logic [7:0] d);
    if (lsb) begin l_valid = 1'b1; l_data = d; end
    else     begin m_valid = 1'b1; m_data = d; end
    step();
    if (lsb) l_valid = 1'b0;
    else     m_valid = 1'b0;
  endtask

  // Checks cycles k+1..k+8; seq holds bits in line order, first bit
  // leftmost. Ends at cycle k+8 without stepping past it.
  task automatic run_word(string tag, bit lsb, logic [7:0] seq,
                          bit noise);
    for (int i = 0; i < 8; i++) begin
      chk_line($sformatf("%s[%0d]", tag, i), lsb,
               seq[7-i], 1'b1, i == 7, i == 7);
      if (noise && i < 7) begin
        m_valid = ~m_valid;
        m_data  = 8'hFF;
      end
      if (i < 7) step();
    end
  endtask

  task automatic idle_chk(string tag, bit lsb);
    step();
    chk_line(tag, lsb, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    m_valid = 1'b0; m_data = 8'h00;
    l_valid = 1'b0; l_data = 8'h00;
    step();
    // transfers must be ignored while held in reset
    m_valid = 1'b1; m_data = 8'hAA;
    l_valid = 1'b1; l_data = 8'hAA;
    step();
    step();
    chk_line("rst_m", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_line("rst_l", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    m_valid = 1'b0;
    l_valid = 1'b0;
    reset_n = 1'b1;
    idle_chk("idle0", 1'b0);

    send(1'b0, 8'hA5);
    run_word("a5", 1'b0, 8'b10100101, 1'b0);
    idle_chk("a5_end", 1'b0);

    send(1'b0, 8'h80);
    run_word("h80", 1'b0, 8'b10000000, 1'b0);
    idle_chk("h80_end", 1'b0);
    send(1'b0, 8'h7F);
    run_word("h7f", 1'b0, 8'b01111111, 1'b0);
    idle_chk("h7f_end", 1'b0);

    send(1'b1, 8'h01);
    run_word("l01", 1'b1, 8'b10000000, 1'b0);
    idle_chk("l01_end", 1'b1);
    send(1'b1, 8'hB4);
    run_word("lb4", 1'b1, 8'b00101101, 1'b0);
    idle_chk("lb4_end", 1'b1);

    // back-to-back: in_valid held; second word accepted on cycle 8
    m_valid = 1'b1; m_data = 8'h3C;
    step();
    m_data = 8'hC3;
    run_word("b2b1", 1'b0, 8'b00111100, 1'b0);
    step();
    m_valid = 1'b0;
    run_word("b2b2", 1'b0, 8'b11000011, 1'b0);
    idle_chk("b2b_end", 1'b0);

    // busy: valid toggling and data FF must not disturb the word
    send(1'b0, 8'h69);
    run_word("busy", 1'b0, 8'b01101001, 1'b1);
    m_valid = 1'b0;
    idle_chk("busy_end", 1'b0);

    // reset asserted mid-word, between clock edges
    send(1'b0, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      chk_line($sformatf("f0[%0d]", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i < 2) step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_line("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    reset_n = 1'b1;
    idle_chk("postrst", 1'b0);
    send(1'b0, 8'h5A);
    run_word("h5a", 1'b0, 8'b01011010, 1'b0);
    idle_chk("h5a_end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso_tx.md
# shift_reg_piso_tx

Parallel-in serial-out shift register transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a serial line. Framing strobes mark the word boundaries. It sits on the transmit side of the serial links built from the team's shift-register family and drives the matching serial-in receiver.

## Interface
- WIDTH, default 8: word width in bits; must be at least 2.
- MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports (reset_n is asynchronous, active-low; clock is clk):
- clk, input, 1: clock; all state changes on the rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: in_data holds a word to send.
- in_ready, output, 1: the block can accept a word this cycle.
- in_data, input, WIDTH: parallel word; all WIDTH bits are loaded.
- ser_out, output, 1: serial data bit.
- ser_frame, output, 1: high on every cycle in which ser_out carries a valid data bit.
- ser_last, output, 1: high on the cycle carrying the final bit of a word.

## Operation
- State machine with two states, IDLE and SHIFT. Reset enters IDLE.
- Datapath:
  - a WIDTH-bit shift register;
  - a bit counter of width $clog2(WIDTH), holding the number of bits remaining after the current one.
- A transfer occurs on a rising edge where in_valid && in_ready.
- in_ready is combinational from state only: 1 in IDLE, 1 in SHIFT when the counter is 0, otherwise 0. It does not depend on in_valid.
- IDLE, on a transfer:
  - load the full in_data into the shift register;
  - counter <= WIDTH-1;
  - go to SHIFT.
- IDLE, with no transfer: ser_out = 0, ser_frame = 0, ser_last = 0.
- SHIFT with counter > 0: shift one position toward the output end and decrement the counter. in_valid is ignored and in_data has no effect.
- SHIFT with counter = 0 (last bit on the line):
  - on a transfer, reload from in_data, counter <= WIDTH-1, stay in SHIFT;
  - with no transfer, go to IDLE.
- Output bit selection:
  - MSB_FIRST=1: ser_out = shift register bit WIDTH-1, and the register shifts left with 0 filled in.
  - MSB_FIRST=0: ser_out = bit 0, and the register shifts right with 0 filled in.
- Framing outputs:
  - ser_frame = (state == SHIFT).
  - ser_last = (state == SHIFT && counter == 0).
- ser_out, ser_frame and ser_last are driven from registers or decoded registered state. There is no combinational path from any input to them.
- No bit of in_data is dropped or truncated. The word loaded is exactly in_data[WIDTH-1:0].

## Timing
- Reset values while reset_n is low: ser_out 0, ser_frame 0, ser_last 0, in_ready 1.
  - Transfers are ignored while reset_n is low.
  - Shift register and counter are cleared to 0.
- Reset asserted mid-word: outputs go to reset values immediately (asynchronously). The partially sent word is discarded and never resumed.
- Latency: a transfer at edge k puts the first bit on ser_out during cycle k+1. Bit i of the sequence appears in cycle k+1+i.
  - ser_frame is high for cycles k+1 through k+WIDTH.
  - ser_last is high in cycle k+WIDTH only.
- Throughput: one word per WIDTH cycles with in_valid held high. Back-to-back words produce a continuous ser_frame with no gap cycle, and ser_last pulses every WIDTH cycles.
- in_data is sampled only at the transfer edge. It may change on any later cycle without affecting the line.
- After the last bit with no new transfer, ser_frame drops in the following cycle and ser_out returns to 0.

## Test plan
- Basic send (WIDTH=8, MSB_FIRST=1): release reset, send 8'hA5 at edge k.
  - ser_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8.
  - ser_frame high for exactly those 8 cycles; ser_last high only in k+8.
  - in_ready low in k+1..k+7 and high in k+8.
- MSB reach: send 8'h80, then 8'h7F.
  - First word gives 1 followed by seven 0s.
  - Second word gives 0 followed by seven 1s. This confirms bit 7 and the low bits are both connected.
- LSB-first (MSB_FIRST=0): send 8'h01 -> 1 then seven 0s. Send 8'hB4 -> 0,0,1,0,1,1,0,1.
- Back-to-back: hold in_valid with 8'h3C, then present 8'hC3 while the first word is shifting.
  - 16 contiguous ser_frame cycles; ser_out = 00111100 followed by 11000011.
  - ser_last high on cycles 8 and 16.
  - Second transfer occurs exactly on cycle 8.
- Busy protection: while a word is mid-shift, toggle in_valid and change in_data to 8'hFF.
  - No transfer occurs, and the line carries the original word unchanged.
- Reset mid-word: start 8'hF0 and assert reset_n low after 3 bits.
  - Outputs read 0 in the same cycle and in_ready reads 1.
  - After release, sending 8'h5A yields 0,1,0,1,1,0,1,0 with correct framing.
